// File: rtl/traffic_lights_cmd_seq.sv
// traffic_lights_cmd_seq
//   Expands high-level host requests (RUN / OFF / RECONFIG) into the ordered
//   command sequence the traffic light controller expects on its command port.
//   Mode commands are held for MODE_HOLD cycles so that they span a controller
//   phase boundary. Config commands are single-cycle pulses. Every command is
//   followed by CMD_GAP idle cycles.
//
// Ports
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   req_valid_i/ready_o   host request handshake (ready only while idle)
//   req_op_i              0=RUN 1=OFF 2=RECONFIG 3=reserved
//   req_*_ms_i            RECONFIG durations, latched at accept
//   cmd_type_o/valid_o/data_o  controller command port (registered)
//   done_o                one-cycle pulse on the last gap cycle of a sequence
//   err_o                 one-cycle pulse the cycle after a rejected request
module traffic_lights_cmd_seq #(
    parameter int MODE_HOLD = 64,
    parameter int CMD_GAP   = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [15:0] req_red_ms_i,
    input  logic [15:0] req_yellow_ms_i,
    input  logic [15:0] req_green_ms_i,
    output logic [2:0]  cmd_type_o,
    output logic        cmd_valid_o,
    output logic [15:0] cmd_data_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int HOLD_W = $clog2(MODE_HOLD + 1);
    localparam int GAP_W  = $clog2(CMD_GAP + 1);

    // Counters hold "cycles already spent" in the state, so the final cycle
    // of a state is the one where the count equals LEN-1 (count+1 reaches LEN).
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MODE_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CMD_GAP - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);

    localparam logic [1:0] OP_RUN   = 2'd0;
    localparam logic [1:0] OP_OFF   = 2'd1;
    localparam logic [1:0] OP_RECFG = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    // RECONFIG steps: 0 mode(2), 1 red, 2 yellow, 3 green, 4 mode(0)
    localparam logic [2:0] STEP_LAST_RECFG = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MODE,
        S_CFG_R,
        S_CFG_Y,
        S_CFG_G,
        S_GAP
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         step_q, step_d;
    logic [1:0]         op_q, op_d;
    logic [15:0]        red_q, red_d;
    logic [15:0]        yel_q, yel_d;
    logic [15:0]        grn_q, grn_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic [2:0]         type_q, type_d;
    logic [15:0]        data_q, data_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               accept;
    logic               illegal;
    logic               last_step_q;
    logic               last_step_d;

    assign accept  = req_valid_i && ready_q;
    assign illegal = (req_op_i == OP_RSVD) ||
                     ((req_op_i == OP_RECFG) &&
                      ((req_red_ms_i == 16'd0) || (req_yellow_ms_i == 16'd0) ||
                       (req_green_ms_i == 16'd0)));

    assign last_step_q = (op_q == OP_RECFG) ? (step_q == STEP_LAST_RECFG) : (step_q == 3'd0);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        op_d    = op_q;
        red_d   = red_q;
        yel_d   = yel_q;
        grn_d   = grn_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = req_op_i;
                        red_d   = req_red_ms_i;
                        yel_d   = req_yellow_ms_i;
                        grn_d   = req_green_ms_i;
                        step_d  = 3'd0;
                        state_d = S_MODE;
                    end
                end
            end
            S_MODE: begin
                if (hold_q == HOLD_LAST) state_d = S_GAP;
                else                     hold_d  = hold_q + HOLD_ONE;
            end
            S_CFG_R, S_CFG_Y, S_CFG_G: state_d = S_GAP;
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (last_step_q) begin
                        state_d = S_IDLE;
                    end else begin
                        step_d = step_q + 3'd1;
                        case (step_q)
                            3'd0:    state_d = S_CFG_R;
                            3'd1:    state_d = S_CFG_Y;
                            3'd2:    state_d = S_CFG_G;
                            default: state_d = S_MODE;
                        endcase
                    end
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Both counters restart on every state entry.
        if (state_d != state_q) begin
            hold_d = '0;
            gap_d  = '0;
        end
    end

    // Output decode from the next state, so every output is a flop.
    assign last_step_d = (op_d == OP_RECFG) ? (step_d == STEP_LAST_RECFG) : (step_d == 3'd0);

    always_comb begin
        ready_d = (state_d == S_IDLE);
        valid_d = 1'b0;
        type_d  = 3'd0;
        data_d  = 16'd0;
        done_d  = (state_d == S_GAP) && last_step_d && (gap_d == GAP_LAST);

        case (state_d)
            S_MODE: begin
                valid_d = 1'b1;
                if (op_d == OP_OFF)                             type_d = 3'd1;
                else if ((op_d == OP_RECFG) && (step_d == 3'd0)) type_d = 3'd2;
                else                                            type_d = 3'd0;
            end
            S_CFG_R: begin valid_d = 1'b1; type_d = 3'd4; data_d = red_d; end
            S_CFG_Y: begin valid_d = 1'b1; type_d = 3'd5; data_d = yel_d; end
            S_CFG_G: begin valid_d = 1'b1; type_d = 3'd3; data_d = grn_d; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            step_q  <= 3'd0;
            op_q    <= OP_RUN;
            red_q   <= 16'd0;
            yel_q   <= 16'd0;
            grn_q   <= 16'd0;
            hold_q  <= '0;
            gap_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            type_q  <= 3'd0;
            data_q  <= 16'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            op_q    <= op_d;
            red_q   <= red_d;
            yel_q   <= yel_d;
            grn_q   <= grn_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            type_q  <= type_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o = ready_q;
    assign cmd_valid_o = valid_q;
    assign cmd_type_o  = type_q;
    assign cmd_data_o  = data_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_traffic_lights_cmd_seq.sv
// Bench for traffic_lights_cmd_seq: a queue-based expected-output model for
// the default instance, literal expectations for directed scenarios, and a
// MODE_HOLD=1/CMD_GAP=1 instance checked against hand-computed timing.
module tb_traffic_lights_cmd_seq;
    localparam int MH = 64;
    localparam int CG = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [15:0] red = 16'd0, yel = 16'd0, grn = 16'd0;
    logic        req_ready_o, cmd_valid_o, done_o, err_o;
    logic [2:0]  cmd_type_o;
    logic [15:0] cmd_data_o;

    logic        v1 = 1'b0;
    logic [1:0]  op1 = 2'd0;
    logic [15:0] r1 = 16'd0, y1 = 16'd0, g1 = 16'd0;
    logic        rdy1, val1, done1, err1;
    logic [2:0]  typ1;
    logic [15:0] dat1;

    traffic_lights_cmd_seq #(.MODE_HOLD(MH), .CMD_GAP(CG)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_op_i(req_op), .req_red_ms_i(red), .req_yellow_ms_i(yel), .req_green_ms_i(grn),
        .cmd_type_o(cmd_type_o), .cmd_valid_o(cmd_valid_o), .cmd_data_o(cmd_data_o),
        .done_o(done_o), .err_o(err_o));

    traffic_lights_cmd_seq #(.MODE_HOLD(1), .CMD_GAP(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(v1), .req_ready_o(rdy1),
        .req_op_i(op1), .req_red_ms_i(r1), .req_yellow_ms_i(y1), .req_green_ms_i(g1),
        .cmd_type_o(typ1), .cmd_valid_o(val1), .cmd_data_o(dat1),
        .done_o(done1), .err_o(err1));

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        v;
        logic [2:0]  t;
        logic [15:0] d;
        logic        done;
        logic        rdy;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t cur;

    function automatic exp_t idle_e();
        exp_t e = '0;
        e.rdy = 1'b1;
        return e;
    endfunction

    // One command: MH valid cycles (mode) or one pulse (config), then CG gaps.
    function automatic void push_cmd(bit mode, int t, int d, bit last);
        exp_t e;
        int n = mode ? MH : 1;
        for (int i = 0; i < n; i++) begin
            e = '0; e.v = 1'b1; e.t = 3'(t); e.d = mode ? 16'd0 : 16'(d);
            q.push_back(e);
        end
        for (int i = 0; i < CG; i++) begin
            e = '0; e.done = last && (i == CG - 1);
            q.push_back(e);
        end
    endfunction

    function automatic void expand(int op, int r, int y, int g);
        exp_t e;
        if (op == 3 || (op == 2 && (r == 0 || y == 0 || g == 0))) begin
            e = '0; e.err = 1'b1; e.rdy = 1'b1;
            q.push_back(e);
        end else if (op == 0) push_cmd(1, 0, 0, 1);
        else if (op == 1) push_cmd(1, 1, 0, 1);
        else begin
            push_cmd(1, 2, 0, 0);
            push_cmd(0, 4, r, 0);
            push_cmd(0, 5, y, 0);
            push_cmd(0, 3, g, 0);
            push_cmd(1, 0, 0, 1);
        end
    endfunction

    initial begin
        cur = idle_e();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                cur = idle_e();
            end else begin
                if (req_valid && cur.rdy) expand(req_op, red, yel, grn);
                cur = (q.size() > 0) ? q.pop_front() : idle_e();
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        exp_t a;
        forever begin
            @(negedge clk);
            a.v = cmd_valid_o; a.t = cmd_type_o; a.d = cmd_data_o;
            a.done = done_o; a.rdy = req_ready_o; a.err = err_o;
            checks++;
            if (a !== cur) begin
                errors++;
                $display("FAIL model actual v=%0b t=%0d d=%0d done=%0b rdy=%0b err=%0b expected v=%0b t=%0d d=%0d done=%0b rdy=%0b err=%0b at %0t",
                         a.v, a.t, a.d, a.done, a.rdy, a.err,
                         cur.v, cur.t, cur.d, cur.done, cur.rdy, cur.err, $time);
            end
        end
    end

    // ---------------- driver helpers ----------------
    int k; // cycle index relative to accept: k=1 is the first cycle after accept

    task automatic send(input logic [1:0] op, input logic [15:0] r, input logic [15:0] y,
                        input logic [15:0] g);
        int n = 0;
        req_op = op; red = r; yel = y; grn = g; req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = 2'($urandom); red = 16'($urandom); yel = 16'($urandom); grn = 16'($urandom);
        k = 1;
    endtask

    task automatic at(input int kk);
        while (k < kk) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("idle_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int cnt;
        // Reset values while reset is held
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready_o, 1);
        chk("rst_valid", cmd_valid_o, 0);
        chk("rst_done_err", {done_o, err_o}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", req_ready_o, 1);

        // RUN
        send(2'd0, 16'd0, 16'd0, 16'd0);
        at(1);   chk("run_v1", cmd_valid_o, 1); chk("run_t1", cmd_type_o, 0);
        at(64);  chk("run_v64", cmd_valid_o, 1);
        at(65);  chk("run_v65", cmd_valid_o, 0);
        at(68);  chk("run_done68", done_o, 1); chk("run_rdy68", req_ready_o, 0);
        at(69);  chk("run_rdy69", req_ready_o, 1); chk("run_done69", done_o, 0);

        // RECONFIG 10/3/7
        send(2'd2, 16'd10, 16'd3, 16'd7);
        at(1);   chk("rc_t1", cmd_type_o, 2); chk("rc_v1", cmd_valid_o, 1);
        at(64);  chk("rc_t64", cmd_type_o, 2);
        at(65);  chk("rc_v65", cmd_valid_o, 0);
        at(69);  chk("rc_t69", cmd_type_o, 4); chk("rc_d69", cmd_data_o, 10);
        at(70);  chk("rc_v70", cmd_valid_o, 0); chk("rc_d70", cmd_data_o, 0);
        at(74);  chk("rc_t74", cmd_type_o, 5); chk("rc_d74", cmd_data_o, 3);
        at(79);  chk("rc_t79", cmd_type_o, 3); chk("rc_d79", cmd_data_o, 7);
        at(84);  chk("rc_v84", cmd_valid_o, 1); chk("rc_t84", cmd_type_o, 0);
        at(147); chk("rc_v147", cmd_valid_o, 1);
        at(148); chk("rc_v148", cmd_valid_o, 0);
        at(150); chk("rc_done150", done_o, 0);
        at(151); chk("rc_done151", done_o, 1);
        at(152); chk("rc_rdy152", req_ready_o, 1);

        // Rejections
        send(2'd3, 16'd1, 16'd1, 16'd1);
        at(1);   chk("rej3_err", err_o, 1); chk("rej3_v", cmd_valid_o, 0); chk("rej3_rdy", req_ready_o, 1);
        at(2);   chk("rej3_err2", err_o, 0); chk("rej3_v2", cmd_valid_o, 0);
        send(2'd2, 16'd5, 16'd5, 16'd0);
        at(1);   chk("rejg_err", err_o, 1); chk("rejg_v", cmd_valid_o, 0); chk("rejg_rdy", req_ready_o, 1);
        at(3);   chk("rejg_v3", cmd_valid_o, 0);

        // Back-pressure: OFF held while RUN is busy
        send(2'd0, 16'd0, 16'd0, 16'd0);
        at(5);
        req_op = 2'd1; red = 16'd9; yel = 16'd9; grn = 16'd9; req_valid = 1'b1;
        at(6);   chk("bp_rdy6", req_ready_o, 0);
        at(68);  chk("bp_rdy68", req_ready_o, 0); chk("bp_done68", done_o, 1);
        at(69);  chk("bp_rdy69", req_ready_o, 1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 2'd2; red = 16'd0;
        k = 70;
        @(negedge clk);
        chk("bp_v70", cmd_valid_o, 1); chk("bp_t70", cmd_type_o, 1);
        at(133); chk("bp_t133", cmd_type_o, 1);
        at(134); chk("bp_v134", cmd_valid_o, 0);
        at(137); chk("bp_done137", done_o, 1);
        wait_idle();

        // Reset mid-RECONFIG
        send(2'd2, 16'd5, 16'd6, 16'd7);
        at(20);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", cmd_valid_o, 0);
        chk("mid_rst_ready", req_ready_o, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (done_o) cnt++;
        end
        chk("mid_rst_no_done", cnt, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 30; i++) begin
            logic [1:0] op;
            logic [15:0] rr, yy, gg;
            op = 2'($urandom_range(0, 3));
            rr = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            yy = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            gg = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            send(op, rr, yy, gg);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        // MODE_HOLD=1, CMD_GAP=1 instance
        @(negedge clk);
        op1 = 2'd2; r1 = 16'd11; y1 = 16'd22; g1 = 16'd33; v1 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0; r1 = 16'd0; op1 = 2'd3;
        for (int kk = 1; kk <= 11; kk++) begin
            @(negedge clk);
            chk("sw_valid", val1, ((kk % 2) == 1 && kk <= 9) ? 1 : 0);
            chk("sw_done", done1, (kk == 10) ? 1 : 0);
            chk("sw_ready", rdy1, (kk == 11) ? 1 : 0);
            if (kk == 1) chk("sw_t1", typ1, 2);
            if (kk == 3) begin chk("sw_t3", typ1, 4); chk("sw_d3", dat1, 11); end
            if (kk == 5) begin chk("sw_t5", typ1, 5); chk("sw_d5", dat1, 22); end
            if (kk == 7) begin chk("sw_t7", typ1, 3); chk("sw_d7", dat1, 33); end
            if (kk == 9) chk("sw_t9", typ1, 0);
        end
        chk("sw_err", err1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/traffic_lights_cmd_seq.md
# traffic_lights_cmd_seq

Command sequencer that drives the traffic light controller's command port (cmd_type/cmd_valid/cmd_data). It accepts high-level host requests (run, off, reconfigure with new red/yellow/green durations) over a valid/ready handshake. It expands each request into the ordered command sequence the controller requires, with mode commands held long enough to span a controller phase boundary and fixed idle gaps between commands. It sits between the host/CSR logic and the traffic light controller.

## Interface
- MODE_HOLD, 64: cycles cmd_valid_o stays high for mode commands (types 0, 1, 2); legal range is 1 or more.
- CMD_GAP, 4: idle cycles (cmd_valid_o=0) after every command; legal range is 1 or more.
- clk_i  in  1  clock; single clock domain.
- rst_n_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  host request valid.
- req_ready_o  out  1  sequencer idle, can accept a request.
- req_op_i  in  2  request opcode: 0=RUN, 1=OFF, 2=RECONFIG, 3=reserved.
- req_red_ms_i  in  16  new red duration (RECONFIG only).
- req_yellow_ms_i  in  16  new yellow duration (RECONFIG only).
- req_green_ms_i  in  16  new green duration (RECONFIG only).
- cmd_type_o  out  3  command type to the controller.
- cmd_valid_o  out  1  command valid.
- cmd_data_o  out  16  command data; equals the duration during a config pulse, 0 otherwise.
- done_o  out  1  one-cycle pulse when a sequence completes.
- err_o  out  1  one-cycle pulse when a request is rejected.

## Operation
- A request is accepted when req_valid_i && req_ready_o.
- All req_* fields are latched at accept; later changes on the inputs have no effect.
- Command sequences:
  - RUN: type 0 (mode).
  - OFF: type 1 (mode).
  - RECONFIG: type 2 (mode), then type 4 with data=red (pulse), then type 5 with data=yellow (pulse), then type 3 with data=green (pulse), then type 0 (mode).
- Mode command: cmd_valid_o=1 with a constant type for MODE_HOLD cycles.
- Config command: cmd_valid_o=1 for exactly one cycle.
- Every command is followed by CMD_GAP cycles with cmd_valid_o=0, cmd_type_o=0 and cmd_data_o=0.
- FSM states: IDLE, MODE, CFG_R, CFG_Y, CFG_G, GAP. A step index selects which command follows GAP.
  - IDLE → MODE on accept of a legal request.
  - MODE → GAP when the hold counter reaches MODE_HOLD.
  - CFG_x → GAP after one cycle.
  - GAP → next command state, or → IDLE after the last gap of the sequence.
- Rejection: op=3, or RECONFIG with any duration equal to 0.
  - err_o pulses one cycle after accept.
  - No command is emitted, the FSM stays in IDLE and req_ready_o stays 1.
- req_ready_o=1 only in IDLE. Requests arriving while busy are back-pressured, never dropped or merged.
- Counters:
  - Hold counter width is $clog2(MODE_HOLD+1); gap counter width is $clog2(CMD_GAP+1).
  - Both are cleared on every state entry and never wrap.
- Outputs are registered; no combinational path from req_* to cmd_*.

## Timing
- Reset values, applied asynchronously on rst_n_i low and holding for the whole time reset is asserted:
  - req_ready_o=1.
  - cmd_valid_o=0, cmd_type_o=0, cmd_data_o=0.
  - done_o=0, err_o=0.
  - FSM=IDLE, all counters=0.
- Reset asserted mid-sequence aborts it immediately: cmd_valid_o drops in the same instant and no done_o is produced.
- Accept at cycle T:
  - First command is valid at T+1.
  - RUN/OFF: valid T+1..T+MODE_HOLD, gap through T+MODE_HOLD+CMD_GAP, done_o at T+MODE_HOLD+CMD_GAP, req_ready_o=1 at T+MODE_HOLD+CMD_GAP+1.
  - RECONFIG total length is 2·MODE_HOLD + 3 + 5·CMD_GAP cycles. done_o is on the last gap cycle; ready returns on the next cycle.
- done_o and req_ready_o are never high in the same cycle, so back-to-back requests start one cycle after done_o.
- err_o is never asserted together with done_o or cmd_valid_o.

## Test plan
- Reset/idle: hold rst_n_i=0, then release → all outputs at reset values and req_ready_o=1. Drop rst_n_i mid-RECONFIG → cmd_valid_o=0 immediately and no done_o.
- RUN, defaults (64/4): accept at T → cmd_type_o=0 with valid T+1..T+64, valid=0 T+65..T+68, done_o at T+68, ready at T+69.
- RECONFIG red=10, yellow=3, green=7, defaults:
  - type 2 at T+1..T+64.
  - type 4/data 10 at T+69.
  - type 5/data 3 at T+74.
  - type 3/data 7 at T+79.
  - type 0 at T+84..T+147.
  - done_o at T+151.
- Rejections: op=3 → err_o at T+1, no cmd_valid_o, ready stays 1. RECONFIG with green=0 → same behaviour.
- Back-pressure: assert a second request (OFF) during a RUN sequence → ready=0 until after done_o. OFF type 1 starts the cycle after acceptance, and its fields are not corrupted by input changes during the wait.
- Parameter sweep with MODE_HOLD=1, CMD_GAP=1 → RECONFIG produces valid pulses at T+1, T+3, T+5, T+7, T+9, and done_o at T+10.
